// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type, default widths and round-robin helper
// for the mem_arbiter slice.
package mem_arb_pkg;

    localparam int MEM_ARB_NUM_REQ    = 2;
    localparam int MEM_ARB_ADDR_WIDTH = 16;
    localparam int MEM_ARB_DATA_WIDTH = 32;

    typedef enum logic {
        S_INIT = 1'b0,
        S_ARB  = 1'b1
    } arb_state_e;

    // Successor of the winning slot, wrapping back to slot 0 after the last one.
    function automatic int unsigned rr_next_ptr(input int unsigned granted,
                                                input int unsigned num_req);
        if (granted + 1 >= num_req) begin
            return 0;
        end
        return granted + 1;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: combinational round-robin grant over NUM_REQ requests
// plus the rotating priority pointer.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = MEM_ARB_NUM_REQ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;

    // Slots at or above the pointer have priority, then the scan wraps to slot 0.
    always_comb begin
        grant_o   = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (enable_i && !win_found && req_i[j] && (PTR_W'(j) >= ptr_q)) begin
                grant_o[j] = 1'b1;
                win_idx    = PTR_W'(j);
                win_found  = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (enable_i && !win_found && req_i[j] && (PTR_W'(j) < ptr_q)) begin
                grant_o[j] = 1'b1;
                win_idx    = PTR_W'(j);
                win_found  = 1'b1;
            end
        end
    end

    // The pointer moves just past the winner; an idle cycle leaves it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (win_found) begin
            ptr_d = PTR_W'(rr_next_ptr(32'(win_idx), NUM_REQ));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between NUM_REQ requesters
// with round-robin grants and a one-cycle read response strobe.
// Optional feature: define MEM_ARB_INIT_EN to fill the whole memory with
// INIT_VALUE after reset before any request is accepted.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    NUM_REQ    = MEM_ARB_NUM_REQ,
    parameter int                    ADDR_WIDTH = MEM_ARB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = MEM_ARB_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b1}}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_wr_en,
    output logic                          mem_rd_en,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          init_done
);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic               arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [NUM_REQ-1:0] rsp_valid_d;

`ifdef MEM_ARB_INIT_EN
    localparam arb_state_e RESET_STATE = S_INIT;

    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] init_cnt_d;
    logic                  init_done_q;
    logic                  init_done_d;
    logic                  init_active;

    // The sweep only drives the memory while reset is released.
    assign init_active = reset && (state_q == S_INIT);
    assign init_done   = init_done_q;
`else
    localparam arb_state_e RESET_STATE = S_ARB;

    assign init_done = 1'b1;
`endif

    // Reset gates the grant directly so every handshake output drops
    // the moment reset asserts, without waiting for a clock edge.
    assign arb_en = reset && (state_q == S_ARB);

    mem_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk      (clk),
        .reset    (reset),
        .enable_i (arb_en),
        .req_i    (req_valid),
        .grant_o  (grant)
    );

    assign req_ready = grant;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the sweep walks every address once, then hands over to arbitration.
    always_comb begin
        state_d = state_q;
`ifdef MEM_ARB_INIT_EN
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (state_q == S_INIT) begin
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == '1) begin
                state_d     = S_ARB;
                init_done_d = 1'b1;
            end
        end
`else
        state_d = S_ARB;
`endif
    end

`ifdef MEM_ARB_INIT_EN
    // Sweep address counter and the sticky done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end
`endif

    // Memory port comes from the sweep or from the single granted requester, else idles at zero.
    always_comb begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_wdata = '0;
`ifdef MEM_ARB_INIT_EN
        if (init_active) begin
            mem_wr_en = 1'b1;
            mem_addr  = init_cnt_q;
            mem_wdata = INIT_VALUE;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                mem_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wr_en = req_wr[i];
                mem_rd_en = ~req_wr[i];
                mem_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rsp_valid_d = grant & ~req_wr;

    // Read strobe lines up with the memory's registered read data one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter with a
// behavioural memory and a reference model of grants and read data.
// Honours MEM_ARB_INIT_EN the same way the design does.
module tb_mem_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] FILL = {DATA_WIDTH{1'b1}};
`ifdef MEM_ARB_INIT_EN
    localparam logic RST_INIT_DONE = 1'b0;
`else
    localparam logic RST_INIT_DONE = 1'b1;
`endif

    typedef struct packed {
        logic [NUM_REQ-1:0]    ready;
        logic                  wr;
        logic                  rd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } port_t;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_wr_en;
    logic                          mem_rd_en;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH-1:0]         mem_rdata;
    logic                          init_done;

    int checks = 0;
    int errors = 0;

    // requester-side command state
    logic [NUM_REQ-1:0]    cmd_valid;
    logic [NUM_REQ-1:0]    cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] cmd_wdata [NUM_REQ];

    // reference model
    int                    ref_ptr;
    logic [DATA_WIDTH-1:0] ref_mem   [DEPTH];
    logic                  ref_known [DEPTH];
    logic [NUM_REQ-1:0]    pend_valid;
    logic [DATA_WIDTH-1:0] pend_data;
    logic                  pend_known;

    // behavioural single-port memory with registered read data
    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    mem_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VALUE (FILL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) mem_array[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem_array[mem_addr];
    end

    // Requester that wins: first valid one counting up from the pointer, wrapping.
    function automatic int exp_grant(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int j = (ref_ptr + k) % NUM_REQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic port_t exp_port(input int g);
        port_t e;
        e = '0;
        if (g >= 0) begin
            e.ready[g] = 1'b1;
            e.wr       = cmd_wr[g];
            e.rd       = ~cmd_wr[g];
            e.addr     = cmd_addr[g];
            e.wdata    = cmd_wdata[g];
        end
        return e;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = cmd_valid[i];
            req_wr[i]    = cmd_wr[i];
            req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = cmd_addr[i];
            req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = cmd_wdata[i];
        end
    endtask

    task automatic set_cmd(input int r, input logic wr, input logic [ADDR_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] d);
        cmd_valid[r] = 1'b1;
        cmd_wr[r]    = wr;
        cmd_addr[r]  = a;
        cmd_wdata[r] = d;
    endtask

    // Clock edge: the model accepts the handshake of requester g (or none).
    task automatic advance(input int g);
        @(posedge clk);
        pend_valid = '0;
        pend_known = 1'b0;
        if (g >= 0) begin
            ref_ptr = (g + 1) % NUM_REQ;
            if (cmd_wr[g]) begin
                ref_mem[cmd_addr[g]]   = cmd_wdata[g];
                ref_known[cmd_addr[g]] = 1'b1;
            end else begin
                pend_valid[g] = 1'b1;
                pend_data     = ref_mem[cmd_addr[g]];
                pend_known    = ref_known[cmd_addr[g]];
            end
            cmd_valid[g] = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_cmd(0, 1'b1, 8'h05, 32'h1234_5678);
        set_cmd(1, 1'b0, 8'h06, 32'h0);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_en: got %b%b want 00", mem_wr_en, mem_rd_en); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("[TB] FAIL reset_mem_bus: got addr %h data %h want 0", mem_addr, mem_wdata); end
        checks++; if (init_done !== RST_INIT_DONE) begin errors++; $display("[TB] FAIL reset_init_done: got %b want %b", init_done, RST_INIT_DONE); end
        cmd_valid  = '0;
        drive();
        ref_ptr    = 0;
        pend_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_init();
        port_t want;
        cmd_valid = '0;
        set_cmd(0, 1'b0, 8'd7, 32'h0);
        drive();
        for (int c = 0; c < DEPTH; c++) begin
            want = '0;
            want.wr    = 1'b1;
            want.addr  = c[ADDR_WIDTH-1:0];
            want.wdata = FILL;
            @(negedge clk);
            checks++;
            if ({req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, init_done} !== {want, 1'b0}) begin
                errors++;
                $display("[TB] FAIL init_sweep[%0d]: got rdy %b wr %b rd %b addr %h data %h done %b", c,
                         req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, init_done);
            end
            advance(-1);
        end
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a]   = FILL;
            ref_known[a] = 1'b1;
        end
        @(negedge clk);
        checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL init_done_after_sweep: got %b want 1", init_done); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL init_first_grant: got %b want 01", req_ready); end
        advance(exp_grant(cmd_valid));
        drive();
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== FILL) begin errors++; $display("[TB] FAIL init_read7: got v %b d %h want 01 %h", rsp_valid, rsp_rdata, FILL); end
        advance(-1);
    endtask

    task automatic test_write_read();
        port_t want;
        cmd_valid = '0;
        set_cmd(0, 1'b1, 8'h10, 32'hDEAD_BEEF);
        drive();
        @(negedge clk);
        want = exp_port(exp_grant(cmd_valid));
        checks++; if ({req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== want) begin errors++; $display("[TB] FAIL wr_port: got %h want %h", {req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata}, want); end
        advance(exp_grant(cmd_valid));
        set_cmd(0, 1'b0, 8'h10, 32'h0);
        drive();
        @(negedge clk);
        checks++; if (req_ready !== 2'b01 || mem_rd_en !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("[TB] FAIL rd_port: got rdy %b rd %b addr %h want 01 1 10", req_ready, mem_rd_en, mem_addr); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rd_early_rsp: got %b want 00", rsp_valid); end
        advance(exp_grant(cmd_valid));
        drive();
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL rd_rsp_valid: got %b want 01", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_rsp_data: got %h want deadbeef", rsp_rdata); end
        advance(-1);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rd_rsp_single: got %b want 00", rsp_valid); end
        advance(-1);
    endtask

    task automatic test_alternating();
        port_t want;
        int    g;
        cmd_valid = '0;
        set_cmd(0, 1'b1, 8'd1, 32'hA1A1_0001);
        set_cmd(1, 1'b1, 8'd2, 32'hB2B2_0002);
        for (int n = 0; n < 10; n++) begin
            if (n == 2) begin
                set_cmd(0, 1'b0, 8'd1, 32'h0);
                set_cmd(1, 1'b0, 8'd2, 32'h0);
            end
            drive();
            @(negedge clk);
            g    = exp_grant(cmd_valid);
            want = exp_port(g);
            checks++; if ({req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== want) begin errors++; $display("[TB] FAIL alt_port[%0d]: got %h want %h", n, {req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata}, want); end
            checks++; if (rsp_valid !== pend_valid) begin errors++; $display("[TB] FAIL alt_rsp_valid[%0d]: got %b want %b", n, rsp_valid, pend_valid); end
            if (pend_valid != '0 && pend_known) begin
                checks++; if (rsp_rdata !== pend_data) begin errors++; $display("[TB] FAIL alt_rsp_data[%0d]: got %h want %h", n, rsp_rdata, pend_data); end
            end
            advance(g);
            if (n >= 1 && g >= 0) cmd_valid[g] = 1'b1;
        end
        cmd_valid = '0;
        drive();
        @(negedge clk);
        checks++; if (rsp_valid !== pend_valid || (pend_known && rsp_rdata !== pend_data)) begin errors++; $display("[TB] FAIL alt_last_rsp: got %b %h want %b %h", rsp_valid, rsp_rdata, pend_valid, pend_data); end
        advance(-1);
    endtask

    task automatic test_ptr_wrap();
        cmd_valid = '0;
        set_cmd(0, 1'b0, 8'd3, 32'h0);
        drive();
        @(negedge clk);
        advance(exp_grant(cmd_valid));
        set_cmd(0, 1'b0, 8'd4, 32'h0);
        drive();
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL ptr_wrap_grant: got %b want 01", req_ready); end
        advance(exp_grant(cmd_valid));
        set_cmd(0, 1'b0, 8'd5, 32'h0);
        set_cmd(1, 1'b0, 8'd6, 32'h0);
        drive();
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL ptr_after_wrap: got %b want 10", req_ready); end
        advance(exp_grant(cmd_valid));
        cmd_valid = '0;
        drive();
        @(negedge clk);
        advance(-1);
    endtask

    task automatic test_idle();
        cmd_valid = '0;
        set_cmd(0, 1'b1, 8'd9, 32'h0909_0909);
        drive();
        @(negedge clk);
        advance(exp_grant(cmd_valid));
        drive();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++; if ({req_ready, mem_wr_en, mem_rd_en} !== '0) begin errors++; $display("[TB] FAIL idle[%0d]: got rdy %b wr %b rd %b want 0", n, req_ready, mem_wr_en, mem_rd_en); end
            advance(-1);
        end
        set_cmd(0, 1'b0, 8'd9, 32'h0);
        set_cmd(1, 1'b0, 8'd9, 32'h0);
        drive();
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL idle_ptr_held: got %b want 10", req_ready); end
        advance(exp_grant(cmd_valid));
        cmd_valid = '0;
        drive();
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h0909_0909) begin errors++; $display("[TB] FAIL idle_read: got %b %h want 10 09090909", rsp_valid, rsp_rdata); end
        advance(-1);
    endtask

    task automatic test_random();
        port_t want;
        int    g;
        cmd_valid = '0;
        for (int n = 0; n < 300; n++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!cmd_valid[r] && $urandom_range(0, 2) != 0) begin
                    set_cmd(r, 1'($urandom_range(0, 1)), ADDR_WIDTH'($urandom_range(0, 15)), $urandom);
                end
            end
            drive();
            @(negedge clk);
            g    = exp_grant(cmd_valid);
            want = exp_port(g);
            checks++; if ({req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== want) begin errors++; $display("[TB] FAIL rand_port[%0d]: got %h want %h", n, {req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata}, want); end
            checks++; if (rsp_valid !== pend_valid) begin errors++; $display("[TB] FAIL rand_rsp_valid[%0d]: got %b want %b", n, rsp_valid, pend_valid); end
            if (pend_valid != '0 && pend_known) begin
                checks++; if (rsp_rdata !== pend_data) begin errors++; $display("[TB] FAIL rand_rsp_data[%0d]: got %h want %h", n, rsp_rdata, pend_data); end
            end
            advance(g);
        end
        cmd_valid = '0;
        drive();
        @(negedge clk);
        advance(-1);
    endtask

    task automatic test_reset_mid();
        cmd_valid = '0;
        set_cmd(0, 1'b0, 8'h10, 32'h0);
        drive();
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL mid_pre_grant: got %b want 01", req_ready); end
        advance(exp_grant(cmd_valid));
        reset = 1'b0;
        set_cmd(0, 1'b0, 8'h10, 32'h0);
        set_cmd(1, 1'b0, 8'h11, 32'h0);
        drive();
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL mid_rsp_dropped: got %b want 00", rsp_valid); end
        checks++; if (req_ready !== 2'b00 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_outputs: got rdy %b rd %b wr %b want 0", req_ready, mem_rd_en, mem_wr_en); end
        ref_ptr    = 0;
        pend_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("[TB] FAIL mid_held: got v %b rdy %b want 00 00", rsp_valid, req_ready); end
        @(posedge clk);
        #1;
        reset = 1'b1;
`ifdef MEM_ARB_INIT_EN
        test_init();
`else
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL mid_ptr_reset: got %b want 01", req_ready); end
        advance(exp_grant(cmd_valid));
        cmd_valid = '0;
        drive();
        @(negedge clk);
        advance(-1);
`endif
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = '0;
        cmd_wr     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_addr[i]  = '0;
            cmd_wdata[i] = '0;
        end
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a]   = '0;
            ref_known[a] = 1'b0;
        end
        ref_ptr    = 0;
        pend_valid = '0;
        pend_data  = '0;
        pend_known = 1'b0;
        drive();

        test_reset();
`ifdef MEM_ARB_INIT_EN
        test_init();
`endif
        test_write_read();
        test_alternating();
        test_ptr_wrap();
        test_idle();
        test_random();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port `memory` instance between NUM_REQ requesters.
- Each requester issues read/write commands over a valid/ready handshake; commands are granted round-robin.
- Accepted commands drive the memory's addr/wr_en/rd_en/wdata directly. Read data is routed back with a per-requester response strobe.
- Optionally runs a post-reset initialisation sweep that fills the memory before any request is accepted.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 32, memory data width
INIT_VALUE, all ones (DATA_WIDTH bits), fill value written by the init sweep

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  NUM_REQ  bit i: requester i has a command
req_ready  output  NUM_REQ  bit i: command i accepted this cycle
req_wr  input  NUM_REQ  bit i: 1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_WIDTH  requester i address in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  requester i write data in slice [i*DATA_WIDTH +: DATA_WIDTH]
rsp_valid  output  NUM_REQ  bit i: read data for requester i valid this cycle
rsp_rdata  output  DATA_WIDTH  read data, shared by all requesters; qualified by rsp_valid
mem_addr  output  ADDR_WIDTH  to memory addr
mem_wr_en  output  1  to memory wr_en
mem_rd_en  output  1  to memory rd_en
mem_wdata  output  DATA_WIDTH  to memory wdata
mem_rdata  input  DATA_WIDTH  from memory rdata (registered in memory, 1-cycle latency)
init_done  output  1  1 once requests can be accepted

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0. rr_ptr=0. Init counter=0. init_done=0 with MEM_ARB_INIT_EN, 1 without it.
- FSM states: S_INIT and S_ARB. Reset enters S_INIT if MEM_ARB_INIT_EN is defined, otherwise S_ARB.
- S_ARB grant (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ. The first i with req_valid[i]=1 gets grant[i]=1. At most one grant per cycle.
  - req_ready = grant. req_ready may depend on req_valid. Requesters must hold valid/command stable until ready.
  - Handshake completes when valid & ready are both 1 at a posedge.
- Memory drive in S_ARB (combinational from the granted slice):
  - mem_addr = granted address.
  - mem_wr_en = granted & req_wr.
  - mem_rd_en = granted & ~req_wr.
  - mem_wdata = granted wdata.
  - With no grant: wr_en=0, rd_en=0, addr=0, wdata=0.
- rr_ptr update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Read response:
  - rsp_valid[i] is a register set for exactly one cycle, the cycle after a read handshake from i.
  - rsp_rdata = mem_rdata (pass-through).
  - Read latency is 1 cycle. There is no response backpressure.
- Writes produce no response.
- Back-to-back accepted commands, one per cycle, are allowed.
- A read in cycle T+1 to an address written in cycle T returns the new data.
- Reset assertion mid-operation: all outputs return to reset values immediately (asynchronous). A pending rsp_valid is dropped. The init sweep restarts from address 0.

Optional Feature:
- Macro: MEM_ARB_INIT_EN.
- Defined:
  - S_INIT drives mem_wr_en=1, mem_addr=counter, mem_wdata=INIT_VALUE, and holds req_ready=0.
  - The counter increments each cycle from 0 to 2**ADDR_WIDTH-1.
  - After the last address is written, go to S_ARB and register init_done=1. The sweep takes 2**ADDR_WIDTH cycles.
- Undefined: S_INIT logic is absent, init_done is tied to 1, and arbitration starts in the first cycle after reset release.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (S_INIT, S_ARB);
  - default width constants;
  - a function for the round-robin next pointer.
- Sub-module mem_rr_arbiter holds the pure round-robin grant logic: req[NUM_REQ] plus rr_ptr in, one-hot grant out, plus the pointer register.

Test Plan:
- MEM_ARB_INIT_EN, ADDR_WIDTH=4: release reset → exactly 16 cycles of mem_wr_en=1 over addresses 0..15 with data 0xFFFFFFFF, then init_done=1. Reading address 7 returns 0xFFFFFFFF.
- Single requester 0 writes 0xDEADBEEF to address 0x0010, then reads address 0x0010 in the next cycle → rsp_valid[0]=1 exactly one cycle after the read handshake, rsp_rdata=0xDEADBEEF, rsp_valid[1]=0.
- Both requesters hold valid continuously with reads to addresses 1 and 2 → grants alternate 0,1,0,1. Each rsp_valid pulse carries the matching address's data.
- rr_ptr=1 and only requester 0 valid → requester 0 granted in the same cycle with no idle cycle. rr_ptr then becomes 1.
- Assert reset in the cycle after a read handshake → rsp_valid stays 0 and req_ready=0. After release with MEM_ARB_INIT_EN, the sweep restarts at address 0.
- No req_valid for 10 cycles → mem_wr_en=mem_rd_en=0 throughout and rr_ptr unchanged.
